// File: rtl/branch_resolve_unit_pkg.sv
// Shared defines for the branch resolve unit: opcode encodings, zero word,
// pattern-history counter states and the saturating counter step.
package branch_resolve_unit_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [7:0] EXE_NOP_OP    = 8'b0000_0000;
  localparam logic [7:0] EXE_BEQ_OP    = 8'b0101_0001;
  localparam logic [7:0] EXE_BNE_OP    = 8'b0101_0010;
  localparam logic [7:0] EXE_BLEZ_OP   = 8'b0101_0011;
  localparam logic [7:0] EXE_BGTZ_OP   = 8'b0101_0100;
  localparam logic [7:0] EXE_BLTZ_OP   = 8'b0100_0000;
  localparam logic [7:0] EXE_BGEZ_OP   = 8'b0100_0001;
  localparam logic [7:0] EXE_BLTZAL_OP = 8'b0100_1010;
  localparam logic [7:0] EXE_BGEZAL_OP = 8'b0100_1011;

  typedef enum logic [1:0] {
    CNT_STRONG_NT = 2'b00,
    CNT_WEAK_NT   = 2'b01,
    CNT_WEAK_T    = 2'b10,
    CNT_STRONG_T  = 2'b11
  } pht_cnt_e;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_STRONG_T) begin
        nxt = cnt + 2'd1;
      end else begin
        nxt = cnt;
      end
    end else begin
      if (cnt != CNT_STRONG_NT) begin
        nxt = cnt - 2'd1;
      end else begin
        nxt = cnt;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_pht.sv
// Pattern history table of 2-bit saturating counters: combinational lookup,
// one registered update per cycle, asynchronous initialisation to weakly not-taken.
module branch_pht
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] cnt_q [DEPTH];
  logic [1:0] cnt_d;

  // Reads the storage directly, so a same-index update this cycle is not yet visible
  always_comb begin
    lookup_taken = cnt_q[lookup_idx][1];
  end

  // Saturating step for the entry being trained
  always_comb begin
    cnt_d = cnt_next(cnt_q[upd_idx], upd_taken);
  end

  // Counter storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_WEAK_NT;
      end
    end else if (upd_en) begin
      cnt_q[upd_idx] <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates MIPS-style conditional branches, registers
// target/redirect/link results, optionally trains a PHT (macro BRANCH_PHT_EN).
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PHT_IDX_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [7:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_imm,
  input  logic              in_pred_taken,
  output logic              out_valid,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic              out_link_en,
  output logic [31:0]       out_target,
  output logic [31:0]       out_redirect_pc,
  output logic [31:0]       out_link,
  input  logic [31:0]       if_pc,
  output logic              if_pred_taken
);

  logic        is_branch_s, taken_s, link_s, accept_s, mispredict_s;
  logic        sign_s, a_zero_s;
  logic [31:0] target_s, seq_pc_s;
  logic        unused_s;

  logic        valid_d, valid_q, taken_d, taken_q;
  logic        mispredict_d, mispredict_q, link_en_d, link_en_q;
  logic [31:0] target_d, target_q, redirect_d, redirect_q, link_d, link_q;

  assign sign_s   = in_a[DATA_W-1];
  assign a_zero_s = (in_a == {DATA_W{1'b0}});
  assign target_s = in_pc + 32'd4 + {in_imm[29:0], 2'b00};
  assign seq_pc_s = in_pc + 32'd8;
  assign accept_s = ~stall & in_valid & is_branch_s;

  // Opcode decode and condition evaluation
  always_comb begin
    is_branch_s = 1'b1;
    taken_s     = 1'b0;
    link_s      = 1'b0;
    case (in_op)
      EXE_BEQ_OP:    taken_s = (in_a == in_b);
      EXE_BNE_OP:    taken_s = (in_a != in_b);
      EXE_BGTZ_OP:   taken_s = ~sign_s & ~a_zero_s;
      EXE_BLEZ_OP:   taken_s = sign_s | a_zero_s;
      EXE_BGEZ_OP:   taken_s = ~sign_s;
      EXE_BLTZ_OP:   taken_s = sign_s;
      EXE_BGEZAL_OP: begin taken_s = ~sign_s; link_s = 1'b1; end
      EXE_BLTZAL_OP: begin taken_s = sign_s;  link_s = 1'b1; end
      default:       is_branch_s = 1'b0;
    endcase
  end

`ifdef BRANCH_PHT_EN
  branch_pht #(.IDX_W(PHT_IDX_W)) u_pht (
    .clk          (clk),
    .resetn       (resetn),
    .lookup_idx   (if_pc[PHT_IDX_W+1:2]),
    .lookup_taken (if_pred_taken),
    .upd_en       (accept_s),
    .upd_idx      (in_pc[PHT_IDX_W+1:2]),
    .upd_taken    (taken_s)
  );
  assign mispredict_s = in_pred_taken ^ taken_s;
`else
  // Fetch always assumes not-taken, so every taken branch is a mispredict
  assign if_pred_taken = 1'b0;
  assign mispredict_s  = taken_s;
`endif

  assign unused_s = ^{if_pc, in_pred_taken};

  // Result register next state: hold on stall, clear when nothing accepted
  always_comb begin
    valid_d      = valid_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    link_en_d    = link_en_q;
    target_d     = target_q;
    redirect_d   = redirect_q;
    link_d       = link_q;
    if (!stall) begin
      valid_d      = accept_s;
      taken_d      = accept_s & taken_s;
      mispredict_d = accept_s & mispredict_s;
      link_en_d    = accept_s & link_s;
      target_d     = accept_s ? target_s : ZeroWord;
      redirect_d   = accept_s ? (taken_s ? target_s : seq_pc_s) : ZeroWord;
      link_d       = (accept_s & link_s) ? seq_pc_s : ZeroWord;
    end else begin
      valid_d = valid_q;
    end
  end

  // Result register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      link_en_q    <= 1'b0;
      target_q     <= ZeroWord;
      redirect_q   <= ZeroWord;
      link_q       <= ZeroWord;
    end else begin
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      link_en_q    <= link_en_d;
      target_q     <= target_d;
      redirect_q   <= redirect_d;
      link_q       <= link_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_taken       = taken_q;
  assign out_mispredict  = mispredict_q;
  assign out_link_en     = link_en_q;
  assign out_target      = target_q;
  assign out_redirect_pc = redirect_q;
  assign out_link        = link_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus random
// traffic compared against a behavioural model (PHT model under BRANCH_PHT_EN).
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, stall, in_valid, in_pred_taken;
  logic [7:0]  in_op;
  logic [31:0] in_a, in_b, in_pc, in_imm, if_pc;
  logic        out_valid, out_taken, out_mispredict, out_link_en, if_pred_taken;
  logic [31:0] out_target, out_redirect_pc, out_link;

  int vectors = 0;
  int miscompares = 0;
  int pht [64];
  logic        e_valid, e_taken, e_mis, e_link_en;
  logic [31:0] e_target, e_redirect, e_link;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(32), .PHT_IDX_W(6)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .in_valid(in_valid), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_link_en(out_link_en), .out_target(out_target), .out_redirect_pc(out_redirect_pc),
    .out_link(out_link), .if_pc(if_pc), .if_pred_taken(if_pred_taken)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void eval(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                               output bit br, output bit tk, output bit lk);
    br = 1'b1; tk = 1'b0; lk = 1'b0;
    if      (op == EXE_BEQ_OP)    tk = (a == b);
    else if (op == EXE_BNE_OP)    tk = (a != b);
    else if (op == EXE_BGTZ_OP)   tk = ($signed(a) > 0);
    else if (op == EXE_BLEZ_OP)   tk = ($signed(a) <= 0);
    else if (op == EXE_BGEZ_OP)   tk = ($signed(a) >= 0);
    else if (op == EXE_BLTZ_OP)   tk = ($signed(a) < 0);
    else if (op == EXE_BGEZAL_OP) begin tk = ($signed(a) >= 0); lk = 1'b1; end
    else if (op == EXE_BLTZAL_OP) begin tk = ($signed(a) < 0);  lk = 1'b1; end
    else br = 1'b0;
  endfunction

  function automatic logic model_pred(input logic [31:0] pc);
`ifdef BRANCH_PHT_EN
    return (pht[pc[7:2]] >= 2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    e_valid = 1'b0; e_taken = 1'b0; e_mis = 1'b0; e_link_en = 1'b0;
    e_target = 32'h0; e_redirect = 32'h0; e_link = 32'h0;
    for (int i = 0; i < 64; i++) pht[i] = 1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"},    {31'h0, out_valid},      {31'h0, e_valid});
    chk({tag, ".taken"},    {31'h0, out_taken},      {31'h0, e_taken});
    chk({tag, ".mispred"},  {31'h0, out_mispredict}, {31'h0, e_mis});
    chk({tag, ".link_en"},  {31'h0, out_link_en},    {31'h0, e_link_en});
    chk({tag, ".target"},   out_target,              e_target);
    chk({tag, ".redirect"}, out_redirect_pc,         e_redirect);
    chk({tag, ".link"},     out_link,                e_link);
  endtask

  // Called just after a falling edge; returns just after the next falling edge
  task automatic step(input logic st, input logic v, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                      input logic pt, input logic [31:0] ipc);
    bit br, tk, lk;
    stall = st; in_valid = v; in_op = op; in_a = a; in_b = b;
    in_pc = pc; in_imm = imm; in_pred_taken = pt; if_pc = ipc;
    #1;
    chk("if_pred", {31'h0, if_pred_taken}, {31'h0, model_pred(ipc)});
    if (!st) begin
      eval(op, a, b, br, tk, lk);
      if (v && br) begin
        e_valid = 1'b1; e_taken = tk; e_link_en = lk;
        e_target = pc + 32'd4 + imm * 32'd4;
        e_redirect = tk ? e_target : pc + 32'd8;
        e_link = lk ? pc + 32'd8 : 32'h0;
`ifdef BRANCH_PHT_EN
        e_mis = (pt != tk);
        if (tk) pht[pc[7:2]] = (pht[pc[7:2]] == 3) ? 3 : pht[pc[7:2]] + 1;
        else    pht[pc[7:2]] = (pht[pc[7:2]] == 0) ? 0 : pht[pc[7:2]] - 1;
`else
        e_mis = tk;
`endif
      end else begin
        e_valid = 1'b0; e_taken = 1'b0; e_mis = 1'b0; e_link_en = 1'b0;
        e_target = 32'h0; e_redirect = 32'h0; e_link = 32'h0;
      end
    end
    @(negedge clk);
    check_outputs("step");
  endtask

  logic [7:0] ops [10];
  logic [31:0] a_pool [5];

  initial begin
    logic [31:0] a, b, pc, ipc;
    ops[0] = EXE_BEQ_OP;  ops[1] = EXE_BNE_OP;  ops[2] = EXE_BLEZ_OP;   ops[3] = EXE_BGTZ_OP;
    ops[4] = EXE_BLTZ_OP; ops[5] = EXE_BGEZ_OP; ops[6] = EXE_BLTZAL_OP; ops[7] = EXE_BGEZAL_OP;
    ops[8] = EXE_NOP_OP;  ops[9] = 8'h25;
    a_pool[0] = 32'h0; a_pool[1] = 32'h1; a_pool[2] = 32'h8000_0000;
    a_pool[3] = 32'hFFFF_FFFF; a_pool[4] = 32'h7FFF_FFFF;

    resetn = 1'b0; stall = 1'b0; in_valid = 1'b0; in_op = 8'h00; in_a = 32'h0; in_b = 32'h0;
    in_pc = 32'h0; in_imm = 32'h0; in_pred_taken = 1'b0; if_pc = 32'h0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // BEQ equal operands
    step(1'b0, 1'b1, EXE_BEQ_OP, 32'd5, 32'd5, 32'h100, 32'd3, 1'b1, 32'h100);
    chk("beq.valid", {31'h0, out_valid}, 32'h1);
    chk("beq.taken", {31'h0, out_taken}, 32'h1);
    chk("beq.target", out_target, 32'h110);
    chk("beq.redirect", out_redirect_pc, 32'h110);

    // Stall with a different branch: everything holds
    step(1'b1, 1'b1, EXE_BNE_OP, 32'd1, 32'd2, 32'h40, 32'd9, 1'b0, 32'h40);
    chk("stall.target", out_target, 32'h110);
    chk("stall.valid", {31'h0, out_valid}, 32'h1);

    // Branch-and-link, taken and not taken
    step(1'b0, 1'b1, EXE_BLTZAL_OP, 32'h8000_0000, 32'h0, 32'h200, 32'h10, 1'b0, 32'h200);
    chk("bltzal.taken", {31'h0, out_taken}, 32'h1);
    chk("bltzal.link_en", {31'h0, out_link_en}, 32'h1);
    chk("bltzal.link", out_link, 32'h208);
    step(1'b0, 1'b1, EXE_BLTZAL_OP, 32'h1, 32'h0, 32'h200, 32'h10, 1'b0, 32'h200);
    chk("bltzal_nt.taken", {31'h0, out_taken}, 32'h0);
    chk("bltzal_nt.link", out_link, 32'h208);
    chk("bltzal_nt.redirect", out_redirect_pc, 32'h208);

    // Target wraps through 2^32
    step(1'b0, 1'b1, EXE_BEQ_OP, 32'h7, 32'h7, 32'hFFFF_FFF0, 32'd4, 1'b1, 32'h0);
    chk("wrap.target", out_target, 32'h0000_0004);

    // Unknown opcode produces no result
    step(1'b0, 1'b1, 8'h25, 32'h3, 32'h3, 32'h300, 32'd1, 1'b0, 32'h300);
    chk("unk.valid", {31'h0, out_valid}, 32'h0);

    // Train the counter at 0x40 with three taken BNEs
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, EXE_BNE_OP, 32'h1, 32'h2, 32'h40, 32'h0, 1'b0, 32'h40);
    if_pc = 32'h40; #1;
`ifdef BRANCH_PHT_EN
    chk("pht40.pred", {31'h0, if_pred_taken}, 32'h1);
    chk("pht40.cnt_model", pht[16], 32'd3);
`else
    chk("pht40.pred", {31'h0, if_pred_taken}, 32'h0);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : a_pool[$urandom_range(0, 4)];
      b = ($urandom_range(0, 1) == 0) ? a : $urandom;
      pc = ($urandom_range(0, 4) == 0) ? $urandom : (32'h40 + 32'd4 * $urandom_range(0, 7));
      ipc = ($urandom_range(0, 1) == 0) ? pc : (32'h40 + 32'd4 * $urandom_range(0, 7));
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0), ops[$urandom_range(0, 9)],
           a, b, pc, $urandom, $urandom_range(0, 1), ipc);
    end

    // Reset in the middle of traffic
    step(1'b0, 1'b1, EXE_BEQ_OP, 32'h9, 32'h9, 32'h40, 32'h2, 1'b0, 32'h40);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs("midreset");
    chk("midreset.valid", {31'h0, out_valid}, 32'h0);
    chk("midreset.mispred", {31'h0, out_mispredict}, 32'h0);
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i) << 2; #1;
      chk("midreset.pred", {31'h0, if_pred_taken}, 32'h0);
    end
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, 1'b1, EXE_BGEZ_OP, 32'h0, 32'h0, 32'h80, 32'h1, 1'b0, 32'h80);
    chk("postreset.valid", {31'h0, out_valid}, 32'h1);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, ops[$urandom_range(0, 9)], a_pool[$urandom_range(0, 4)], $urandom,
           32'h80, $urandom, $urandom_range(0, 1), 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
